// File: rtl/pwm_deadband_pkg.sv
// -----------------------------------------------------------------------------
// pwm_deadband_pkg
//   Shared types and defaults for the complementary dead-time generator.
//   - dt_state_e       : per-channel gate FSM state encoding
//   - DT_WIDTH_DEFAULT : default dead-time counter width (cycles)
// -----------------------------------------------------------------------------
package pwm_deadband_pkg;

    localparam int DT_WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_LO    = 3'd1,
        ST_DT_LH = 3'd2,
        ST_HI    = 3'd3,
        ST_DT_HL = 3'd4
    } dt_state_e;

endpackage

// File: rtl/pwm_dt_channel.sv
// -----------------------------------------------------------------------------
// pwm_dt_channel
//   One dead-time channel: gate FSM, dead-time down-counter and output decode.
//   Ports:
//     clk_i      in  clock
//     rst_ni     in  asynchronous active-low reset
//     run_i      in  channel may drive (enable, valid, no fault)
//     pwm_i      in  raw PWM level
//     dt_rise_i  in  dead time before high-side turn-on (cycles)
//     dt_fall_i  in  dead time before low-side turn-on (cycles)
//     hi_o       out high-side gate
//     lo_o       out low-side gate
//     oe_o       out channel is driving (state not OFF)
// -----------------------------------------------------------------------------
module pwm_dt_channel
    import pwm_deadband_pkg::*;
#(
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run_i,
    input  logic                pwm_i,
    input  logic [DT_WIDTH-1:0] dt_rise_i,
    input  logic [DT_WIDTH-1:0] dt_fall_i,
    output logic                hi_o,
    output logic                lo_o,
    output logic                oe_o
);

    dt_state_e           state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;

    // Counter preload on entry to a dead-time state. The interval lasts
    // cnt+1 cycles, so load dt-1; a zero dead time still yields one cycle
    // (only used on the OFF->DT_LH path, where a gap is mandatory).
    function automatic logic [DT_WIDTH-1:0] dt_load(input logic [DT_WIDTH-1:0] dt);
        return (dt == '0) ? '0 : dt - 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run_i) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    // Leaving OFF toward the high side always passes through
                    // dead time, so a fault recovery can never shoot through.
                    if (pwm_i) begin
                        state_d = ST_DT_LH;
                        cnt_d   = dt_load(dt_rise_i);
                    end else begin
                        state_d = ST_LO;
                    end
                end
                ST_LO: begin
                    if (pwm_i) begin
                        if (dt_rise_i == '0) begin
                            state_d = ST_HI;
                        end else begin
                            state_d = ST_DT_LH;
                            cnt_d   = dt_load(dt_rise_i);
                        end
                    end
                end
                ST_DT_LH: begin
                    if (!pwm_i) begin
                        state_d = ST_LO;
                    end else if (cnt_q == '0) begin
                        state_d = ST_HI;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_HI: begin
                    if (!pwm_i) begin
                        if (dt_fall_i == '0) begin
                            state_d = ST_LO;
                        end else begin
                            state_d = ST_DT_HL;
                            cnt_d   = dt_load(dt_fall_i);
                        end
                    end
                end
                ST_DT_HL: begin
                    if (pwm_i) begin
                        state_d = ST_HI;
                    end else if (cnt_q == '0) begin
                        state_d = ST_LO;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Decode straight from the state register: a single state can never
    // assert both gates, and async reset clears them without a clock.
    assign hi_o = (state_q == ST_HI);
    assign lo_o = (state_q == ST_LO);
    assign oe_o = (state_q != ST_OFF);

endmodule

// File: rtl/pwm_deadband.sv
// -----------------------------------------------------------------------------
// pwm_deadband
//   Complementary dead-time generator for CH PWM channels with a sticky fault.
//   Ports:
//     clk_i        in  clock (PWM core clock)
//     rst_ni       in  asynchronous active-low reset
//     en_i         in  global enable
//     pwm_i        in  [CH] raw PWM per channel
//     pwm_oe_i     in  [CH] PWM valid per channel
//     dt_rise_i    in  [DT_WIDTH] dead time before high-side turn-on
//     dt_fall_i    in  [DT_WIDTH] dead time before low-side turn-on
//     fault_i      in  external fault, active-high
//     fault_clr_i  in  pulse clearing the latched fault
//     pwm_hi_o     out [CH] high-side gates
//     pwm_lo_o     out [CH] low-side gates
//     oe_o         out [CH] channel driving
//     fault_o      out latched fault flag
// -----------------------------------------------------------------------------
module pwm_deadband
    import pwm_deadband_pkg::*;
#(
    parameter int CH       = 2,
    parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [CH-1:0]       pwm_i,
    input  logic [CH-1:0]       pwm_oe_i,
    input  logic [DT_WIDTH-1:0] dt_rise_i,
    input  logic [DT_WIDTH-1:0] dt_fall_i,
    input  logic                fault_i,
    input  logic                fault_clr_i,
    output logic [CH-1:0]       pwm_hi_o,
    output logic [CH-1:0]       pwm_lo_o,
    output logic [CH-1:0]       oe_o,
    output logic                fault_o
);

    logic          fault_q;
    logic [CH-1:0] run;

    // Set dominates clear so a clear pulse during an active fault is ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fault_q <= 1'b0;
        end else if (fault_i) begin
            fault_q <= 1'b1;
        end else if (fault_clr_i) begin
            fault_q <= 1'b0;
        end
    end

    assign fault_o = fault_q;

    // Raw fault_i is included so the gates drop on the same edge the fault
    // is first seen, not one cycle later via the latch.
    assign run = pwm_oe_i & {CH{en_i & ~fault_q & ~fault_i}};

    for (genvar c = 0; c < CH; c++) begin : g_ch
        pwm_dt_channel #(
            .DT_WIDTH (DT_WIDTH)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .run_i     (run[c]),
            .pwm_i     (pwm_i[c]),
            .dt_rise_i (dt_rise_i),
            .dt_fall_i (dt_fall_i),
            .hi_o      (pwm_hi_o[c]),
            .lo_o      (pwm_lo_o[c]),
            .oe_o      (oe_o[c])
        );
    end

endmodule

// File: tb/tb_pwm_deadband.sv
module tb_pwm_deadband;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       en_i;
    logic [1:0] pwm_i;
    logic [1:0] pwm_oe_i;
    logic [7:0] dt_rise_i;
    logic [7:0] dt_fall_i;
    logic       fault_i;
    logic       fault_clr_i;
    logic [1:0] pwm_hi_o;
    logic [1:0] pwm_lo_o;
    logic [1:0] oe_o;
    logic       fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_deadband #(.CH(2), .DT_WIDTH(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .pwm_i       (pwm_i),
        .pwm_oe_i    (pwm_oe_i),
        .dt_rise_i   (dt_rise_i),
        .dt_fall_i   (dt_fall_i),
        .fault_i     (fault_i),
        .fault_clr_i (fault_clr_i),
        .pwm_hi_o    (pwm_hi_o),
        .pwm_lo_o    (pwm_lo_o),
        .oe_o        (oe_o),
        .fault_o     (fault_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: {hi, lo, oe, fault} against expected values.
    task automatic chk_all(input string tag, input logic [1:0] hi, input logic [1:0] lo,
                           input logic [1:0] oe, input logic flt);
        chk({tag, ".hi"}, {6'd0, pwm_hi_o}, {6'd0, hi});
        chk({tag, ".lo"}, {6'd0, pwm_lo_o}, {6'd0, lo});
        chk({tag, ".oe"}, {6'd0, oe_o}, {6'd0, oe});
        chk({tag, ".fault"}, {7'd0, fault_o}, {7'd0, flt});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Shoot-through must never happen in any cycle.
    always @(negedge clk_i) begin
        n_checks++;
        assert ((pwm_hi_o & pwm_lo_o) === 2'b00) else begin
            n_fail++;
            $error("FAIL overlap: observed hi&lo=%0b expected 0", pwm_hi_o & pwm_lo_o);
        end
    end

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; pwm_i = 2'b00; pwm_oe_i = 2'b00;
        dt_rise_i = 8'd0; dt_fall_i = 8'd0; fault_i = 1'b0; fault_clr_i = 1'b0;
        tick();
        tick();
        chk_all("reset", 2'b00, 2'b00, 2'b00, 1'b0);
        rst_ni = 1'b1;

        // Dead time 3 rising / 5 falling; channel 1 stays low throughout.
        en_i = 1'b1; pwm_oe_i = 2'b11; dt_rise_i = 8'd3; dt_fall_i = 8'd5;
        tick();
        chk_all("start_lo", 2'b00, 2'b11, 2'b11, 1'b0);
        pwm_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("rise_gap", 2'b00, 2'b10, 2'b11, 1'b0);
        end
        tick();
        chk_all("rise_hi", 2'b01, 2'b10, 2'b11, 1'b0);
        tick();
        chk_all("hold_hi", 2'b01, 2'b10, 2'b11, 1'b0);
        pwm_i = 2'b00;
        tick();
        chk_all("fall_gap0", 2'b00, 2'b10, 2'b11, 1'b0);
        dt_fall_i = 8'd1;  // must not shorten the interval already running
        for (int i = 1; i < 5; i++) begin
            tick();
            chk_all("fall_gap", 2'b00, 2'b10, 2'b11, 1'b0);
        end
        tick();
        chk_all("fall_lo", 2'b00, 2'b11, 2'b11, 1'b0);

        // Zero dead time: direct complementary tracking, 1-cycle latency.
        dt_rise_i = 8'd0; dt_fall_i = 8'd0;
        pwm_i = 2'b01;
        tick();
        chk_all("dt0_hi", 2'b01, 2'b10, 2'b11, 1'b0);
        pwm_i = 2'b00;
        tick();
        chk_all("dt0_lo", 2'b00, 2'b11, 2'b11, 1'b0);
        pwm_i = 2'b11;
        tick();
        chk_all("dt0_hi2", 2'b11, 2'b00, 2'b11, 1'b0);
        pwm_i = 2'b00;
        tick();
        chk_all("dt0_lo2", 2'b00, 2'b11, 2'b11, 1'b0);

        // Pulse shorter than dead time is swallowed.
        dt_rise_i = 8'd6;
        pwm_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_all("swallow", 2'b00, 2'b10, 2'b11, 1'b0);
        end
        pwm_i = 2'b00;
        tick();
        chk_all("swallow_lo", 2'b00, 2'b11, 2'b11, 1'b0);

        // Fault while in HI.
        dt_rise_i = 8'd0;
        pwm_i = 2'b01;
        tick();
        chk_all("pre_fault", 2'b01, 2'b10, 2'b11, 1'b0);
        fault_i = 1'b1;
        tick();
        chk_all("fault", 2'b00, 2'b00, 2'b00, 1'b1);
        fault_i = 1'b0;
        tick();
        chk_all("fault_hold", 2'b00, 2'b00, 2'b00, 1'b1);
        fault_i = 1'b1; fault_clr_i = 1'b1;
        tick();
        chk_all("fault_setwins", 2'b00, 2'b00, 2'b00, 1'b1);
        fault_i = 1'b0;
        tick();
        chk_all("fault_clr", 2'b00, 2'b00, 2'b00, 1'b0);
        fault_clr_i = 1'b0;
        tick();
        chk_all("recover_dtlh", 2'b00, 2'b10, 2'b11, 1'b0);
        tick();
        chk_all("recover_hi", 2'b01, 2'b10, 2'b11, 1'b0);

        // Channel 1 valid drop; channel 0 continues.
        pwm_oe_i = 2'b01;
        tick();
        chk_all("ch1_off", 2'b01, 2'b00, 2'b01, 1'b0);
        pwm_i = 2'b00;
        tick();
        chk_all("ch0_alone_lo", 2'b00, 2'b01, 2'b01, 1'b0);
        pwm_oe_i = 2'b11;
        tick();
        chk_all("ch1_back", 2'b00, 2'b11, 2'b11, 1'b0);

        // Asynchronous reset in the middle of a rising dead time.
        dt_rise_i = 8'd4;
        pwm_i = 2'b01;
        tick();
        chk_all("pre_rst_dtlh", 2'b00, 2'b10, 2'b11, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_all("async_rst", 2'b00, 2'b00, 2'b00, 1'b0);
        dt_rise_i = 8'd2;
        tick();
        chk_all("rst_held", 2'b00, 2'b00, 2'b00, 1'b0);
        rst_ni = 1'b1;
        tick();
        chk_all("post_rst_dtlh", 2'b00, 2'b10, 2'b11, 1'b0);
        tick();
        chk_all("post_rst_gap", 2'b00, 2'b10, 2'b11, 1'b0);
        tick();
        chk_all("post_rst_hi", 2'b01, 2'b10, 2'b11, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
